// File: rtl/midori_inv_affine_pipe_pkg.sv
// Shared definitions for the Midori inverse-affine share pipeline:
// affine select encodings and the number of shares.
package midori_inv_affine_pipe_pkg;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IN     = 2'd1,
    SEL_OUT    = 2'd2,
    SEL_MID    = 2'd3
  } sel_e;

  localparam int NUM_SHARES = 3;

endpackage

// File: rtl/midori_inv_affine_pipe_if.sv
// Handshake and share bus of the inverse-affine pipeline, with master
// (producer/consumer side) and slave (pipeline side) views.
interface midori_inv_affine_pipe_if #(
  parameter int DEPTH_CNT = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_sel;
  logic [3:0]           x1;
  logic [3:0]           x2;
  logic [3:0]           x3;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           y1;
  logic [3:0]           y2;
  logic [3:0]           y3;
  logic [DEPTH_CNT-1:0] tx_count;

  modport master (
    output in_valid, in_sel, x1, x2, x3, out_ready,
    input  in_ready, out_valid, y1, y2, y3, tx_count
  );

  modport slave (
    input  in_valid, in_sel, x1, x2, x3, out_ready,
    output in_ready, out_valid, y1, y2, y3, tx_count
  );
endinterface

// File: rtl/midori_inv_affine_share.sv
// Combinational inverse affine map for one share; the only share-dependent
// difference is which share carries the complemented constant bit.
module midori_inv_affine_share
  import midori_inv_affine_pipe_pkg::*;
#(
  parameter int SHARE_IDX = 1
) (
  input  sel_e       sel,
  input  logic [3:0] x,
  output logic [3:0] y
);

  // Constant-one terms are injected into exactly one share so the XOR of shares is correct.
  localparam logic OUT_FLIP = (SHARE_IDX == 3);
  localparam logic MID_FLIP = (SHARE_IDX == 1);

  always_comb begin
    y = x;
    case (sel)
      SEL_BYPASS: y = x;
      SEL_IN:     y = {x[2], x[3] ^ x[1], x[0], x[1]};
      SEL_OUT:    y = {x[2] ^ x[0], x[0], x[3] ^ OUT_FLIP, x[1]};
      SEL_MID:    y = {x[0] ^ x[1], x[3] ^ x[2] ^ MID_FLIP, x[1], x[2]};
      default:    y = x;
    endcase
  end

endmodule

// File: rtl/midori_inv_affine_pipe.sv
// Two-stage valid/ready pipeline applying a selectable Midori inverse affine
// map to three isolated shares, with a saturating count of emitted results.
module midori_inv_affine_pipe
  import midori_inv_affine_pipe_pkg::*;
#(
  parameter int DEPTH_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [3:0]           x1,
  input  logic [3:0]           x2,
  input  logic [3:0]           x3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           y1,
  output logic [3:0]           y2,
  output logic [3:0]           y3,
  output logic [DEPTH_CNT-1:0] tx_count
);

  logic                             a_valid_q, a_valid_d;
  sel_e                             a_sel_q, a_sel_d;
  logic [NUM_SHARES-1:0][3:0]       a_x_q, a_x_d;
  logic                             b_valid_q, b_valid_d;
  logic [NUM_SHARES-1:0][3:0]       b_y_q, b_y_d;
  logic [NUM_SHARES-1:0][3:0]       map_y;
  logic [DEPTH_CNT-1:0]             tx_q, tx_d;
  logic                             a_adv;
  logic                             b_adv;

  // Each share gets its own map instance fed only by its own stage-A register.
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
    midori_inv_affine_share #(
      .SHARE_IDX(i + 1)
    ) u_share (
      .sel(a_sel_q),
      .x  (a_x_q[i]),
      .y  (map_y[i])
    );
  end

  assign b_adv = !b_valid_q || out_ready;
  assign a_adv = !a_valid_q || b_adv;

  always_comb begin
    a_valid_d = a_valid_q;
    a_sel_d   = a_sel_q;
    a_x_d     = a_x_q;
    b_valid_d = b_valid_q;
    b_y_d     = b_y_q;
    tx_d      = tx_q;

    if (a_adv) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_sel_d  = sel_e'(in_sel);
        a_x_d[0] = x1;
        a_x_d[1] = x2;
        a_x_d[2] = x3;
      end
    end

    if (b_adv) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_y_d = map_y;
      end
    end

    if (b_valid_q && out_ready && (tx_q != {DEPTH_CNT{1'b1}})) begin
      tx_d = tx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_sel_q   <= SEL_BYPASS;
      a_x_q     <= '0;
      b_valid_q <= 1'b0;
      b_y_q     <= '0;
      tx_q      <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_sel_q   <= a_sel_d;
      a_x_q     <= a_x_d;
      b_valid_q <= b_valid_d;
      b_y_q     <= b_y_d;
      tx_q      <= tx_d;
    end
  end

  assign in_ready  = a_adv;
  assign out_valid = b_valid_q;
  assign y1        = b_y_q[0];
  assign y2        = b_y_q[1];
  assign y3        = b_y_q[2];
  assign tx_count  = tx_q;

endmodule

// File: tb/tb_midori_inv_affine_pipe.sv
// Scoreboard bench for midori_inv_affine_pipe: expected shares are queued on
// accept and compared as results leave; a second instance checks saturation.
module tb_midori_inv_affine_pipe;

  logic clk;
  logic rst;

  midori_inv_affine_pipe_if #(.DEPTH_CNT(8)) ifc ();
  midori_inv_affine_pipe_if #(.DEPTH_CNT(2)) ifs ();

  midori_inv_affine_pipe #(.DEPTH_CNT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ifc.in_valid),
    .in_ready (ifc.in_ready),
    .in_sel   (ifc.in_sel),
    .x1       (ifc.x1),
    .x2       (ifc.x2),
    .x3       (ifc.x3),
    .out_valid(ifc.out_valid),
    .out_ready(ifc.out_ready),
    .y1       (ifc.y1),
    .y2       (ifc.y2),
    .y3       (ifc.y3),
    .tx_count (ifc.tx_count)
  );

  midori_inv_affine_pipe #(.DEPTH_CNT(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ifs.in_valid),
    .in_ready (ifs.in_ready),
    .in_sel   (ifs.in_sel),
    .x1       (ifs.x1),
    .x2       (ifs.x2),
    .x3       (ifs.x3),
    .out_valid(ifs.out_valid),
    .out_ready(ifs.out_ready),
    .y1       (ifs.y1),
    .y2       (ifs.y2),
    .y3       (ifs.y3),
    .tx_count (ifs.tx_count)
  );

  typedef struct {
    logic [3:0] y1;
    logic [3:0] y2;
    logic [3:0] y3;
    logic [3:0] xr;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] fwd [4][4][16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference inverse affine maps, written directly from the bit equations.
  function automatic logic [3:0] ref_map(input int sel, input int sh, input logic [3:0] x);
    case (sel)
      1: return {x[2], x[3] ^ x[1], x[0], x[1]};
      2: return (sh == 3) ? {x[2] ^ x[0], x[0], ~x[3], x[1]} : {x[2] ^ x[0], x[0], x[3], x[1]};
      3: return (sh == 1) ? {x[0] ^ x[1], ~(x[3] ^ x[2]), x[1], x[2]}
                          : {x[0] ^ x[1], x[3] ^ x[2], x[1], x[2]};
      default: return x;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL stale_output: got y=%h %h %h with nothing pending", ifc.y1, ifc.y2, ifc.y3);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({ifc.y1, ifc.y2, ifc.y3} !== {e.y1, e.y2, e.y3}) begin
          errors++;
          $display("[TB] FAIL out_shares: got %h %h %h expected %h %h %h",
                   ifc.y1, ifc.y2, ifc.y3, e.y1, e.y2, e.y3);
        end
        checks++;
        if ((ifc.y1 ^ ifc.y2 ^ ifc.y3) !== e.xr) begin
          errors++;
          $display("[TB] FAIL share_xor: got %h expected %h", ifc.y1 ^ ifc.y2 ^ ifc.y3, e.xr);
        end
      end
    end
  end

  // One clock of stimulus; starts and ends 1 time unit after a rising edge.
  task automatic step(input bit v, input logic [1:0] s, input logic [3:0] a, b, c,
                      input logic [3:0] e1, e2, e3, input bit ordy, output bit acc);
    exp_t e;
    ifc.in_valid  = v;
    ifc.in_sel    = s;
    ifc.x1        = a;
    ifc.x2        = b;
    ifc.x3        = c;
    ifc.out_ready = ordy;
    @(negedge clk);
    acc = v && ifc.in_ready;
    if (acc) begin
      e.y1 = e1; e.y2 = e2; e.y3 = e3; e.xr = e1 ^ e2 ^ e3;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [3:0] a, b, c, input bit ordy, output bit acc);
    step(1'b1, s, a, b, c, ref_map(int'(s), 1, a), ref_map(int'(s), 2, b), ref_map(int'(s), 3, c), ordy, acc);
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, ordy, acc);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() > 0; i++) idle(1'b1);
  endtask

  task automatic test_reset;
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ifc.out_valid);
    end
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", ifc.in_ready);
    end
    checks++;
    if (ifc.tx_count !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_tx_count: got %0d expected 0", ifc.tx_count);
    end
    checks++;
    if ({ifc.y1, ifc.y2, ifc.y3} !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_y: got %h %h %h expected 0 0 0", ifc.y1, ifc.y2, ifc.y3);
    end
  endtask

  task automatic test_directed;
    bit acc;
    send(2'd1, 4'b1010, 4'b1010, 4'b1010, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("[TB] FAIL sel1_accept: got %b expected 1", acc);
    end
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL sel1_early_valid: got %b expected 0", ifc.out_valid);
    end
    idle(1'b1);
    checks++;
    if ({ifc.out_valid, ifc.y1, ifc.y2, ifc.y3} !== {1'b1, 12'h111}) begin
      errors++; $display("[TB] FAIL sel1_result: got v=%b y=%h %h %h expected v=1 y=1 1 1",
                         ifc.out_valid, ifc.y1, ifc.y2, ifc.y3);
    end
    idle(1'b1);
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL sel1_single_valid: got %b expected 0", ifc.out_valid);
    end
    send(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, acc);
    send(2'd3, 4'h0, 4'h0, 4'h0, 1'b1, acc);
    checks++;
    if ({ifc.y1, ifc.y2, ifc.y3} !== 12'h002) begin
      errors++; $display("[TB] FAIL sel2_zero: got %h %h %h expected 0 0 2", ifc.y1, ifc.y2, ifc.y3);
    end
    idle(1'b1);
    checks++;
    if ({ifc.y1, ifc.y2, ifc.y3} !== 12'h400) begin
      errors++; $display("[TB] FAIL sel3_zero: got %h %h %h expected 4 0 0", ifc.y1, ifc.y2, ifc.y3);
    end
    drain(10);
  endtask

  task automatic test_round_trip;
    bit         acc;
    logic [3:0] v1, v2, v3;
    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 16; v++) begin
        v1 = 4'(v);
        v2 = 4'(v + 5);
        v3 = 4'(v + 11);
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
          step(1'b1, 2'(s), fwd[s][1][v1], fwd[s][2][v2], fwd[s][3][v3], v1, v2, v3,
               $urandom_range(0, 3) != 0, acc);
        end
        checks++;
        if (!acc) begin
          errors++; $display("[TB] FAIL round_trip_accept: got no accept expected accept sel=%0d v=%0d", s, v);
        end
      end
    end
    drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL round_trip_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    bit acc;
    int sent  = 0;
    int stall = -1;
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    sb.delete();
    for (int cyc = 0; cyc < 30 && sent < 5; cyc++) begin
      send(2'(sent % 4), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), cyc >= 4, acc);
      if (acc) sent++;
      else if (stall < 0) stall = sent;
    end
    checks++;
    if (stall !== 2) begin
      errors++; $display("[TB] FAIL b2b_stall_point: got %0d accepts expected 2", stall);
    end
    drain(20);
    checks++;
    if (sb.size() != 0 || sent != 5) begin
      errors++; $display("[TB] FAIL b2b_complete: got sent=%0d pending=%0d expected 5 and 0", sent, sb.size());
    end
    checks++;
    if (ifc.tx_count !== 8'd5) begin
      errors++; $display("[TB] FAIL b2b_tx_count: got %0d expected 5", ifc.tx_count);
    end
  endtask

  task automatic test_reset_midflight;
    bit acc;
    int seen = 0;
    send(2'd1, 4'h3, 4'h7, 4'hc, 1'b0, acc);
    send(2'd3, 4'h9, 4'h1, 4'he, 1'b0, acc);
    rst           = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_sel    = 2'd2;
    ifc.x1        = 4'hf;
    ifc.x2        = 4'hf;
    ifc.x3        = 4'hf;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    ifc.in_valid = 1'b0;
    sb.delete();
    checks++;
    if ({ifc.out_valid, ifc.in_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL midreset_handshake: got out_valid=%b in_ready=%b expected 0 1",
                         ifc.out_valid, ifc.in_ready);
    end
    checks++;
    if (ifc.tx_count !== 8'd0) begin
      errors++; $display("[TB] FAIL midreset_tx_count: got %0d expected 0", ifc.tx_count);
    end
    checks++;
    if ({ifc.y1, ifc.y2, ifc.y3} !== 12'h000) begin
      errors++; $display("[TB] FAIL midreset_y: got %h %h %h expected 0 0 0", ifc.y1, ifc.y2, ifc.y3);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      if (ifc.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("[TB] FAIL midreset_stale: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_saturate;
    int  accepted = 0;
    int  xfers    = 0;
    bit  mid_done = 1'b0;
    ifs.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && xfers < 6; cyc++) begin
      ifs.in_valid = (accepted < 6);
      ifs.x1       = 4'(cyc);
      @(negedge clk);
      if (ifs.in_valid && ifs.in_ready) accepted++;
      if (ifs.out_valid && ifs.out_ready) xfers++;
      @(posedge clk);
      #1;
      if (xfers == 2 && !mid_done) begin
        mid_done = 1'b1;
        checks++;
        if (ifs.tx_count !== 2'd2) begin
          errors++; $display("[TB] FAIL sat_mid_count: got %0d expected 2", ifs.tx_count);
        end
      end
    end
    ifs.in_valid = 1'b0;
    checks++;
    if (xfers != 6) begin
      errors++; $display("[TB] FAIL sat_transfers: got %0d expected 6", xfers);
    end
    checks++;
    if (ifs.tx_count !== 2'd3) begin
      errors++; $display("[TB] FAIL sat_tx_count: got %0d expected 3", ifs.tx_count);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int s = 0; s < 4; s++)
      for (int sh = 1; sh < 4; sh++)
        for (int u = 0; u < 16; u++)
          fwd[s][sh][ref_map(s, sh, 4'(u))] = 4'(u);

    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_sel    = 2'd0;
    ifc.x1        = 4'h0;
    ifc.x2        = 4'h0;
    ifc.x3        = 4'h0;
    ifc.out_ready = 1'b0;
    ifs.in_valid  = 1'b0;
    ifs.in_sel    = 2'd0;
    ifs.x1        = 4'h0;
    ifs.x2        = 4'h0;
    ifs.x3        = 4'h0;
    ifs.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_directed();
    test_round_trip();
    test_back_to_back();
    test_reset_midflight();
    test_saturate();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
